// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep slice.
// Holds the sweep FSM state encoding, default word widths and the
// waveform codes shared by key_control and the dds core.
package dds_pkg;

  localparam int FW_W_DEF    = 32;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  localparam logic [3:0] WAVE_SINE   = 4'h0;
  localparam logic [3:0] WAVE_TRI    = 4'h1;
  localparam logic [3:0] WAVE_SAW    = 4'h2;
  localparam logic [3:0] WAVE_SQUARE = 4'h3;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable dwell down-counter.
// Ports: clk/rst (sync, active-high), load + load_val reload the count,
// en counts down one per cycle, expire is high on the last enabled cycle
// of the dwell (count 1, or a stale 0 so the sweep can never stall).
module dds_dwell_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expire = en && (cnt <= W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller.
// Steps freq_word from f_start up to f_stop by f_step, holding each value
// for max(cfg_dwell,1) dwell cycles followed by one STEP cycle in which the
// next word is computed. Optional loop, abort, and (with DDS_SWEEP_BIDIR_EN
// defined) an up/down sweep selected by the latched bidir_en input.
// Ports: sys_clk, sys_rst (sync, active-high); start/abort pulses; loop_en
// (sampled live); cfg_* latched at start; freq_word/wave_select to the DDS;
// busy, step_tick (new freq_word this cycle), done (one-cycle end pulse).
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW_W    = FW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic [3:0]         cfg_wave,
  input  logic [FW_W-1:0]    cfg_f_start,
  input  logic [FW_W-1:0]    cfg_f_stop,
  input  logic [FW_W-1:0]    cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef DDS_SWEEP_BIDIR_EN
  input  logic               bidir_en,
`endif
  output logic [FW_W-1:0]    freq_word,
  output logic [3:0]         wave_select,
  output logic               busy,
  output logic               step_tick,
  output logic               done
);

  sweep_state_e         state, state_nxt;
  logic [FW_W-1:0]      f_start_q, f_stop_q, f_step_q, fw_nxt, up_val;
  logic [DWELL_W-1:0]   dwell_q, cnt_load_val;
  logic [FW_W:0]        sum_up;
  logic                 start_go, step_go, at_stop, at_end, expire;

  assign start_go     = (state == ST_IDLE) && start;
  assign step_go      = (state == ST_STEP) && !abort;
  assign cnt_load_val = start_go ? ((cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell) : dwell_q;
  assign at_stop      = (freq_word == f_stop_q);

  // One extra bit so a step past the top of the word range clamps
  // instead of wrapping. A zero step also clamps, so a sweep always ends.
  assign sum_up = {1'b0, freq_word} + {1'b0, f_step_q};
  assign up_val = (f_step_q == '0 || sum_up >= {1'b0, f_stop_q}) ? f_stop_q : sum_up[FW_W-1:0];

`ifdef DDS_SWEEP_BIDIR_EN
  logic            bidir_q, dir_down, dir_nxt;
  logic [FW_W:0]   diff_dn;
  logic [FW_W-1:0] dn_val;

  // Down-step clamps at f_start on borrow, zero step, or undershoot.
  assign diff_dn = {1'b0, freq_word} - {1'b0, f_step_q};
  assign dn_val  = (f_step_q == '0 || diff_dn[FW_W] || diff_dn[FW_W-1:0] <= f_start_q)
                   ? f_start_q : diff_dn[FW_W-1:0];
  assign at_end  = bidir_q ? (dir_down && freq_word == f_start_q) : at_stop;

  always_comb begin
    dir_nxt = dir_down;
    fw_nxt  = up_val;
    if (dir_down) begin
      if (freq_word == f_start_q) begin
        fw_nxt  = f_start_q;   // loop restart: climb again from f_start
        dir_nxt = 1'b0;
      end else begin
        fw_nxt  = dn_val;
      end
    end else if (at_stop) begin
      if (bidir_q) begin
        fw_nxt  = dn_val;
        dir_nxt = 1'b1;
      end else begin
        fw_nxt  = f_start_q;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bidir_q  <= 1'b0;
      dir_down <= 1'b0;
    end else if (start_go) begin
      bidir_q  <= bidir_en;
      dir_down <= 1'b0;
    end else if (step_go) begin
      dir_down <= dir_nxt;
    end
  end
`else
  assign at_end = at_stop;
  // STEP is only reached at f_stop when looping, so reload f_start there.
  assign fw_nxt = at_stop ? f_start_q : up_val;
`endif

  dds_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .load     (start_go || step_go),
    .load_val (cnt_load_val),
    .en       (state == ST_DWELL),
    .expire   (expire)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_DWELL;
      ST_DWELL: begin
        if (abort || (expire && at_end && !loop_en)) state_nxt = ST_FINISH;
        else if (expire)                             state_nxt = ST_STEP;
      end
      ST_STEP:   state_nxt = abort ? ST_FINISH : ST_DWELL;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      freq_word   <= '0;
      wave_select <= '0;
      step_tick   <= 1'b0;
      f_start_q   <= '0;
      f_stop_q    <= '0;
      f_step_q    <= '0;
      dwell_q     <= '0;
    end else begin
      step_tick <= 1'b0;
      if (start_go) begin
        f_start_q   <= cfg_f_start;
        f_stop_q    <= cfg_f_stop;
        f_step_q    <= cfg_f_step;
        dwell_q     <= cnt_load_val;
        wave_select <= cfg_wave;
        freq_word   <= cfg_f_start;
        step_tick   <= 1'b1;
      end else if (step_go) begin
        freq_word   <= fw_nxt;
        step_tick   <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule
